// File: rtl/vigna_coproc_pkg.sv
// Shared definitions for the Vigna coprocessor dispatcher: opcode
// constants, FSM state encoding, response error codes and the
// instruction classifier used at accept time.
package vigna_coproc_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_FP        = 7'b1010011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Dispatcher FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_M = 2'd1;
  localparam logic [1:0] ST_WAIT_F = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Response error codes
  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_ILL = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  typedef enum logic [1:0] {
    CLS_ILL = 2'd0,
    CLS_M   = 2'd1,
    CLS_F   = 2'd2
  } insn_class_e;

  // Decide which unit (if any) owns a raw instruction word.
  function automatic insn_class_e classify(input logic [31:0] insn);
    insn_class_e cls;
    if ((insn[6:0] == OPC_OP) && (insn[31:25] == FUNCT7_MULDIV)) begin
      cls = CLS_M;
    end else if (insn[6:0] == OPC_FP) begin
      cls = CLS_F;
    end else begin
      cls = CLS_ILL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/vigna_coproc_dispatch.sv
// Coprocessor issue stage: accepts one instruction from the core, routes it
// to the M or F unit (or flags it illegal), waits for completion or timeout,
// and returns the result on a valid/ready response channel. One operation
// is outstanding at a time.
module vigna_coproc_dispatch
  import vigna_coproc_pkg::*;
#(
  parameter  int TIMEOUT = 255,
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cp_valid,
  output logic        cp_ready,
  input  logic [31:0] cp_insn,
  input  logic [31:0] cp_rs1,
  input  logic [31:0] cp_rs2,
  output logic        cp_resp_valid,
  input  logic        cp_resp_ready,
  output logic [31:0] cp_resp_data,
  output logic [4:0]  cp_resp_rd,
  output logic [1:0]  cp_resp_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [2:0]  m_func,
  output logic [2:0]  m_id,
  output logic [31:0] m_op1,
  output logic [31:0] m_op2,
  input  logic [31:0] m_result,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [2:0]  f_func,
  output logic [4:0]  f_func2,
  output logic [31:0] f_op1,
  output logic [31:0] f_op2,
  input  logic [31:0] f_result
);

  logic [1:0]    state_q,     state_d;
  logic [4:0]    rd_q,        rd_d;
  logic [2:0]    func3_q,     func3_d;
  logic [4:0]    func2_q,     func2_d;
  logic [31:0]   op1_q,       op1_d;
  logic [31:0]   op2_q,       op2_d;
  logic          saw_low_q,   saw_low_d;
  logic [TW-1:0] cnt_q,       cnt_d;
  logic          m_valid_q,   m_valid_d;
  logic          f_valid_q,   f_valid_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic [1:0]    resp_err_q,  resp_err_d;

  logic          sel_ready_s;
  logic [31:0]   sel_result_s;
  logic [TW-1:0] cnt_inc_s;

  // Select the handshake/result of whichever unit is being waited on.
  always_comb begin
    sel_ready_s  = 1'b0;
    sel_result_s = 32'h0000_0000;
    if (state_q == ST_WAIT_M) begin
      sel_ready_s  = m_ready;
      sel_result_s = m_result;
    end else if (state_q == ST_WAIT_F) begin
      sel_ready_s  = f_ready;
      sel_result_s = f_result;
    end else begin
      sel_ready_s  = 1'b0;
      sel_result_s = 32'h0000_0000;
    end
  end

  assign cnt_inc_s = cnt_q + TW'(1);

  // Next-state logic: accept/decode, completion detection, timeout, response.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    func3_d     = func3_q;
    func2_d     = func2_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    saw_low_d   = saw_low_q;
    cnt_d       = cnt_q;
    m_valid_d   = 1'b0;
    f_valid_d   = 1'b0;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cp_valid) begin
          rd_d      = cp_insn[11:7];
          func3_d   = cp_insn[14:12];
          func2_d   = cp_insn[31:27];
          op1_d     = cp_rs1;
          op2_d     = cp_rs2;
          saw_low_d = 1'b0;
          cnt_d     = '0;
          case (classify(cp_insn))
            CLS_M: begin
              state_d   = ST_WAIT_M;
              m_valid_d = 1'b1;
            end
            CLS_F: begin
              state_d   = ST_WAIT_F;
              f_valid_d = 1'b1;
            end
            default: begin
              state_d     = ST_RESP;
              resp_data_d = 32'h0000_0000;
              resp_err_d  = ERR_ILL;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_M, ST_WAIT_F: begin
        // The F unit's ready is high while idle, so a ready seen before any
        // low sample is not a completion.
        if (sel_ready_s && saw_low_q) begin
          state_d     = ST_RESP;
          resp_data_d = sel_result_s;
          resp_err_d  = ERR_OK;
          saw_low_d   = 1'b0;
          cnt_d       = '0;
        end else if (cnt_inc_s == TW'(TIMEOUT)) begin
          // Clearing saw_low makes any late ready from the unit harmless.
          state_d     = ST_RESP;
          resp_data_d = 32'h0000_0000;
          resp_err_d  = ERR_TMO;
          saw_low_d   = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc_s;
          if (!sel_ready_s) begin
            saw_low_d = 1'b1;
          end else begin
            saw_low_d = saw_low_q;
          end
        end
      end

      ST_RESP: begin
        if (cp_resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rd_q        <= 5'd0;
      func3_q     <= 3'd0;
      func2_q     <= 5'd0;
      op1_q       <= 32'h0000_0000;
      op2_q       <= 32'h0000_0000;
      saw_low_q   <= 1'b0;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      f_valid_q   <= 1'b0;
      resp_data_q <= 32'h0000_0000;
      resp_err_q  <= ERR_OK;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      func3_q     <= func3_d;
      func2_q     <= func2_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      saw_low_q   <= saw_low_d;
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      f_valid_q   <= f_valid_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Operand/func buses stay stable from accept until the next accept.
  assign cp_ready      = (state_q == ST_IDLE);
  assign cp_resp_valid = (state_q == ST_RESP);
  assign cp_resp_data  = resp_data_q;
  assign cp_resp_rd    = rd_q;
  assign cp_resp_err   = resp_err_q;

  assign m_valid = m_valid_q;
  assign m_func  = func3_q;
  assign m_id    = 3'b000;
  assign m_op1   = op1_q;
  assign m_op2   = op2_q;

  assign f_valid = f_valid_q;
  assign f_func  = func3_q;
  assign f_func2 = func2_q;
  assign f_op1   = op1_q;
  assign f_op2   = op2_q;

endmodule

// File: tb/tb_vigna_coproc_dispatch.sv
// Directed bench for vigna_coproc_dispatch with behavioural M and F unit stubs.
module tb_vigna_coproc_dispatch;

  logic        clk;
  logic        resetn;
  logic        cp_valid;
  logic        cp_ready;
  logic [31:0] cp_insn;
  logic [31:0] cp_rs1;
  logic [31:0] cp_rs2;
  logic        cp_resp_valid;
  logic        cp_resp_ready;
  logic [31:0] cp_resp_data;
  logic [4:0]  cp_resp_rd;
  logic [1:0]  cp_resp_err;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  m_func;
  logic [2:0]  m_id;
  logic [31:0] m_op1;
  logic [31:0] m_op2;
  logic [31:0] m_result;
  logic        f_valid;
  logic        f_ready;
  logic [2:0]  f_func;
  logic [4:0]  f_func2;
  logic [31:0] f_op1;
  logic [31:0] f_op2;
  logic [31:0] f_result;

  int checks   = 0;
  int failures = 0;

  logic m_never;
  logic m_busy;
  int   m_cnt;
  logic f_busy;
  int   m_pulses = 0;
  int   f_pulses = 0;

  vigna_coproc_dispatch #(.TIMEOUT(40)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cp_valid      (cp_valid),
    .cp_ready      (cp_ready),
    .cp_insn       (cp_insn),
    .cp_rs1        (cp_rs1),
    .cp_rs2        (cp_rs2),
    .cp_resp_valid (cp_resp_valid),
    .cp_resp_ready (cp_resp_ready),
    .cp_resp_data  (cp_resp_data),
    .cp_resp_rd    (cp_resp_rd),
    .cp_resp_err   (cp_resp_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_func        (m_func),
    .m_id          (m_id),
    .m_op1         (m_op1),
    .m_op2         (m_op2),
    .m_result      (m_result),
    .f_valid       (f_valid),
    .f_ready       (f_ready),
    .f_func        (f_func),
    .f_func2       (f_func2),
    .f_op1         (f_op1),
    .f_op2         (f_op2),
    .f_result      (f_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // M unit stub: ready pulse 35 edges after accept, 3 for divide-by-zero.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ready  <= 1'b0;
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      m_result <= 32'h0;
    end else begin
      m_ready <= 1'b0;
      if (m_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= (m_op2 == 32'h0) ? 1 : 33;
        if (m_func == 3'b101)
          m_result <= (m_op2 == 32'h0) ? 32'hFFFF_FFFF : m_op1 / m_op2;
        else
          m_result <= m_op1 * m_op2;
      end else if (m_busy && !m_never) begin
        if (m_cnt == 1) begin
          m_ready <= 1'b1;
          m_busy  <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // F unit stub: idle-high ready, one busy cycle, result = op1 (move).
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      f_ready  <= 1'b1;
      f_busy   <= 1'b0;
      f_result <= 32'h0;
    end else if (f_valid && f_ready) begin
      f_ready <= 1'b0;
      f_busy  <= 1'b1;
    end else if (f_busy) begin
      f_ready  <= 1'b1;
      f_busy   <= 1'b0;
      f_result <= f_op1;
    end
  end

  // Count issue pulses seen by the units.
  always @(posedge clk) begin
    if (m_valid) m_pulses <= m_pulses + 1;
    if (f_valid) f_pulses <= f_pulses + 1;
  end

  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    @(negedge clk);
    cp_valid = 1'b1;
    cp_insn  = insn;
    cp_rs1   = rs1;
    cp_rs2   = rs2;
    @(posedge clk);
    #1;
    cp_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    logic done;
    done = 1'b0;
    lat  = -1;
    for (int i = 1; i <= 100; i++) begin
      if (!done) begin
        @(posedge clk);
        #1;
        if (cp_resp_valid) begin
          lat  = i;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    cp_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    cp_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cp_valid = 1'b0; cp_insn = 32'h0; cp_rs1 = 32'h0; cp_rs2 = 32'h0;
    cp_resp_ready = 1'b0; m_never = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cp_ready !== 1'b1) begin failures++; $display("FAIL reset_cp_ready got=%0b exp=1", cp_ready); end
    checks++; if (cp_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b exp=0", cp_resp_valid); end
    checks++; if ({m_valid, f_valid} !== 2'b00) begin failures++; $display("FAIL reset_unit_valid got=%b exp=00", {m_valid, f_valid}); end
    checks++; if (cp_resp_data !== 32'h0 || cp_resp_err !== 2'd0 || cp_resp_rd !== 5'd0) begin
      failures++; $display("FAIL reset_resp got data=%h err=%0d rd=%0d exp 0/0/0", cp_resp_data, cp_resp_err, cp_resp_rd); end
    checks++; if (m_op1 !== 32'h0 || f_func2 !== 5'd0 || m_id !== 3'd0) begin
      failures++; $display("FAIL reset_buses got op1=%h func2=%h id=%0d exp 0", m_op1, f_func2, m_id); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int m0, lat;
    m0 = m_pulses;
    issue(32'h02B50533, 32'd7, 32'd6);
    checks++; if (m_valid !== 1'b1 || f_valid !== 1'b0) begin failures++; $display("FAIL mul_issue got m=%0b f=%0b exp m=1 f=0", m_valid, f_valid); end
    checks++; if (m_func !== 3'd0 || m_op1 !== 32'd7 || m_op2 !== 32'd6) begin
      failures++; $display("FAIL mul_buses got func=%0d op1=%0d op2=%0d exp 0/7/6", m_func, m_op1, m_op2); end
    checks++; if (cp_ready !== 1'b0) begin failures++; $display("FAIL mul_busy_ready got=%0b exp=0", cp_ready); end
    wait_resp(lat);
    checks++; if (lat != 35) begin failures++; $display("FAIL mul_latency got=%0d exp=35", lat); end
    checks++; if (cp_resp_data !== 32'd42 || cp_resp_rd !== 5'd10 || cp_resp_err !== 2'd0) begin
      failures++; $display("FAIL mul_resp got data=%0d rd=%0d err=%0d exp 42/10/0", cp_resp_data, cp_resp_rd, cp_resp_err); end
    checks++; if (m_pulses - m0 != 1) begin failures++; $display("FAIL mul_pulses got=%0d exp=1", m_pulses - m0); end
    handshake();
    checks++; if (cp_resp_valid !== 1'b0 || cp_ready !== 1'b1) begin
      failures++; $display("FAIL mul_handshake got valid=%0b ready=%0b exp 0/1", cp_resp_valid, cp_ready); end
  endtask

  task automatic test_divu_zero();
    int m0, lat;
    m0 = m_pulses;
    issue(32'h02B55533, 32'h1234, 32'h0);
    checks++; if (m_func !== 3'b101) begin failures++; $display("FAIL divu_func got=%b exp=101", m_func); end
    wait_resp(lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL divu_latency got=%0d exp=3", lat); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (cp_resp_data !== 32'hFFFF_FFFF || cp_resp_err !== 2'd0) begin
      failures++; $display("FAIL divu_resp got data=%h err=%0d exp ffffffff/0", cp_resp_data, cp_resp_err); end
    checks++; if (m_pulses - m0 != 1) begin failures++; $display("FAIL divu_pulses got=%0d exp=1", m_pulses - m0); end
    handshake();
  endtask

  task automatic test_fmv();
    int f0, m0, lat;
    f0 = f_pulses; m0 = m_pulses;
    issue(32'hF0050553, 32'h40490FDB, 32'h0);
    checks++; if (f_valid !== 1'b1 || f_func2 !== 5'h1E || f_func !== 3'd0 || f_op1 !== 32'h40490FDB) begin
      failures++; $display("FAIL fmv_issue got v=%0b func2=%h func=%0d op1=%h exp 1/1e/0/40490fdb", f_valid, f_func2, f_func, f_op1); end
    wait_resp(lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL fmv_latency got=%0d exp=3", lat); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cp_resp_data !== 32'h40490FDB || cp_resp_rd !== 5'd10 || cp_resp_err !== 2'd0) begin
      failures++; $display("FAIL fmv_resp got data=%h rd=%0d err=%0d exp 40490fdb/10/0", cp_resp_data, cp_resp_rd, cp_resp_err); end
    checks++; if (f_pulses - f0 != 1 || m_pulses != m0) begin
      failures++; $display("FAIL fmv_pulses got f=%0d m=%0d exp f=1 m=0", f_pulses - f0, m_pulses - m0); end
    handshake();
  endtask

  task automatic test_illegal();
    int f0, m0, lat;
    f0 = f_pulses; m0 = m_pulses;
    issue(32'h00000013, 32'h5, 32'h6);
    wait_resp(lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL ill_latency got=%0d exp=1", lat); end
    checks++; if (cp_resp_data !== 32'h0 || cp_resp_err !== 2'd1) begin
      failures++; $display("FAIL ill_resp got data=%h err=%0d exp 0/1", cp_resp_data, cp_resp_err); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (f_pulses != f0 || m_pulses != m0) begin
      failures++; $display("FAIL ill_no_issue got f=%0d m=%0d exp 0/0", f_pulses - f0, m_pulses - m0); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic stable_ok;
    issue(32'h02B50533, 32'd3, 32'd5);
    wait_resp(lat);
    checks++; if (lat != 35 || cp_resp_data !== 32'd15) begin
      failures++; $display("FAIL bp_resp got lat=%0d data=%0d exp 35/15", lat, cp_resp_data); end
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cp_resp_valid !== 1'b1 || cp_resp_data !== 32'd15 || cp_ready !== 1'b0 || cp_resp_rd !== 5'd10) stable_ok = 1'b0;
    end
    checks++; if (stable_ok !== 1'b1) begin failures++; $display("FAIL bp_stable got=%0b exp=1", stable_ok); end
    @(negedge clk);
    cp_resp_ready = 1'b1;
    cp_valid      = 1'b1;
    cp_insn       = 32'h00000013;
    #1;
    checks++; if (cp_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_in_resp got=%0b exp=0", cp_ready); end
    @(posedge clk);
    #1;
    cp_resp_ready = 1'b0;
    checks++; if (cp_resp_valid !== 1'b0 || cp_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got valid=%0b ready=%0b exp 0/1", cp_resp_valid, cp_ready); end
    @(posedge clk);
    #1;
    cp_valid = 1'b0;
    checks++; if (cp_resp_valid !== 1'b1 || cp_resp_err !== 2'd1 || cp_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_accept got valid=%0b err=%0d ready=%0b exp 1/1/0", cp_resp_valid, cp_resp_err, cp_ready); end
    handshake();
  endtask

  task automatic test_timeout();
    int lat;
    m_never = 1'b1;
    issue(32'h02B50533, 32'd2, 32'd2);
    wait_resp(lat);
    checks++; if (lat != 40) begin failures++; $display("FAIL tmo_latency got=%0d exp=40", lat); end
    checks++; if (cp_resp_err !== 2'd2 || cp_resp_data !== 32'h0) begin
      failures++; $display("FAIL tmo_resp got err=%0d data=%h exp 2/0", cp_resp_err, cp_resp_data); end
    handshake();
    checks++; if (cp_ready !== 1'b1) begin failures++; $display("FAIL tmo_idle got=%0b exp=1", cp_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(32'h02B50533, 32'd9, 32'd4);
    repeat (5) @(posedge clk);
    #3;
    checks++; if (cp_ready !== 1'b0) begin failures++; $display("FAIL rmid_waiting got=%0b exp=0", cp_ready); end
    resetn = 1'b0;
    #1;
    checks++; if (cp_ready !== 1'b1 || cp_resp_valid !== 1'b0 || m_op1 !== 32'h0 || m_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_reset got ready=%0b valid=%0b op1=%h mv=%0b exp 1/0/0/0", cp_ready, cp_resp_valid, m_op1, m_valid); end
    @(negedge clk);
    resetn  = 1'b1;
    m_never = 1'b0;
    issue(32'hF0050553, 32'h3F800000, 32'h0);
    wait_resp(lat);
    checks++; if (lat != 3 || cp_resp_data !== 32'h3F800000) begin
      failures++; $display("FAIL rmid_recover got lat=%0d data=%h exp 3/3f800000", lat, cp_resp_data); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divu_zero();
    test_fmv();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vigna_coproc_dispatch.md
Name: vigna_coproc_dispatch

Overview:
Upstream issue stage for the coprocessor units. It accepts one decoded-candidate instruction plus operands from the core, classifies it as M-extension, F-extension or illegal, and issues it to vigna_m_ext or vigna_f_ext. It then waits for completion and returns the result to the core over a valid/ready response channel. Exactly one operation is outstanding at a time.

Parameters:
TIMEOUT, 255, max cycles from issue to completion before an error response is generated (≥ 40)
TW, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cp_valid  in  1  core presents instruction
cp_ready  out  1  dispatcher can accept (high only in IDLE)
cp_insn  in  32  raw instruction word
cp_rs1  in  32  rs1 operand value
cp_rs2  in  32  rs2 operand value
cp_resp_valid  out  1  response available
cp_resp_ready  in  1  core consumes response
cp_resp_data  out  32  result
cp_resp_rd  out  5  destination register (cp_insn[11:7] latched)
cp_resp_err  out  2  0 ok, 1 illegal, 2 timeout
m_valid  out  1  one-cycle issue pulse to M unit
m_ready  in  1  M unit completion pulse
m_func  out  3  cp_insn[14:12] latched
m_id  out  3  constant 0
m_op1, m_op2  out  32  latched rs1/rs2
m_result  in  32  M unit result
f_valid  out  1  one-cycle issue pulse to F unit
f_ready  in  1  F unit ready (high when idle)
f_func  out  3  cp_insn[14:12] latched
f_func2  out  5  cp_insn[31:27] latched
f_op1, f_op2  out  32  latched rs1/rs2
f_result  in  32  F unit result

Behaviour:
- Reset: all outputs 0 except cp_ready=1; state=IDLE; saw_low=0; counter=0. Reset mid-operation aborts; the units reset on the same resetn.
- Decode: opcode[6:0]=0110011 and funct7=0000001 → M. opcode=1010011 → F. Anything else → illegal.
- States: IDLE, WAIT_M, WAIT_F, RESP.
- IDLE: cp_ready=1. On cp_valid at an edge, latch insn fields, rs1 and rs2.
  - M: state→WAIT_M, m_valid=1 for exactly one cycle.
  - F: state→WAIT_F, f_valid=1 for exactly one cycle.
  - Illegal: state→RESP with data=0, err=1 (response visible 1 cycle after accept).
- Valid is a pulse, never held. Both units re-accept if valid is seen in their idle state. Op/func buses stay stable from accept until the response handshake, because the M unit reads op1/op2/func throughout.
- Completion rule (both units): clear saw_low at issue. Set saw_low when the selected ready is sampled 0. Completion is the first edge where ready=1 and saw_low=1. This ignores the F unit's idle-high ready in the issue cycle.
- On completion: capture m_result or f_result into cp_resp_data, err=0, state→RESP.
- Timeout: the counter increments each WAIT cycle. At count==TIMEOUT: state→RESP, data=0, err=2. A late ready is then ignored because saw_low is cleared.
- RESP: cp_resp_valid=1 and outputs are held until cp_resp_ready. On handshake: state→IDLE, cp_resp_valid→0. A new instruction is accepted no earlier than the following cycle. cp_ready=0 in RESP even if cp_resp_ready is high.
- Latency (accept edge → cp_resp_valid high):
  - F ops: 3 cycles.
  - M mul/div: 35 cycles.
  - M divide-by-zero and signed-overflow: 3 cycles.
  - Illegal: 1 cycle.

Decomposition:
- Shared package vigna_coproc_pkg holds:
  - opcode constants OPC_OP=7'b0110011 and OPC_FP=7'b1010011
  - FUNCT7_MULDIV=7'b0000001
  - state encoding
  - err codes ERR_OK/ERR_ILL/ERR_TMO
- No sub-module; the decode is a small combinational block inside the FSM module.

Test Plan:
- MUL: cp_insn=0x02B50533 (mul a0,a0,a1), rs1=7, rs2=6 → one m_valid pulse; cp_resp_valid 35 cycles after accept with data=42, rd=10, err=0.
- DIVU by zero: funct3=101, rs1=0x1234, rs2=0 → data=0xFFFFFFFF at 3 cycles; m_valid never re-pulses.
- FMV.W.X: funct7=1111000, funct3=000, rs1=0x40490FDB → f_valid one pulse; data=0x40490FDB at 3 cycles, no second F accept.
- Illegal: cp_insn=0x00000013 → data=0, err=1 at 1 cycle; no unit valid.
- Backpressure: hold cp_resp_ready=0 for 10 cycles after a MUL → data/valid stable, cp_ready=0. Release → IDLE, and the next cp_valid is accepted the cycle after.
- Timeout/reset: TIMEOUT=40 with a stub M unit that never readies → err=2 at 40 cycles. Assert resetn low mid-WAIT_M → outputs reset immediately, cp_ready=1.
